// File: rtl/bit_serializer_if.sv
// Handshake and serial-output bundle for bit_serializer.
// master: upstream word source / downstream observer; slave: the serializer itself.
interface bit_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             frame_done;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  sout,
    input  sout_valid,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output sout,
    output sout_valid,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clock out.
// Back-to-back words stream with no idle gap between frames.
// Optional build macro BIT_SERIALIZER_LSB_FIRST_EN: din[0] leaves first (default MSB first).
module bit_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  bit_serializer_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CntW-1:0]  cnt_q;

  logic             last_bit;
  logic             accept;
  logic             head;
  logic [WIDTH-1:0] shift_next;

  // Bit order selection: head bit on the line and the one-position advance.
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
  assign head       = shift_q[0];
  assign shift_next = {1'b0, shift_q[WIDTH-1:1]};
`else
  assign head       = shift_q[WIDTH-1];
  assign shift_next = {shift_q[WIDTH-2:0], 1'b0};
`endif

  assign last_bit = (state_q == StShift) && (cnt_q == LastCnt);

  // Ready is forced low during reset so nothing is accepted on a reset edge.
  assign bus.din_ready = rst_n && ((state_q == StIdle) || last_bit);
  assign accept        = bus.din_valid && bus.din_ready;

  // Outputs decode straight from state registers; the line idles at 0.
  assign bus.sout       = (state_q == StShift) && head;
  assign bus.sout_valid = (state_q == StShift);
  assign bus.busy       = (state_q == StShift);
  assign bus.frame_done = last_bit;

  // Frame FSM with shift register and bit counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            shift_q <= bus.din;
            cnt_q   <= '0;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (cnt_q != LastCnt) begin
            shift_q <= shift_next;
            cnt_q   <= cnt_q + 1'b1;
          end else if (accept) begin
            // Reload on the last bit so the next frame follows with no gap.
            shift_q <= bus.din;
            cnt_q   <= '0;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
